// File: rtl/grid_line_clear_ctrl_pkg.sv
// grid_pkg: shared geometry, cell/grid types and FSM state encoding for the
// playfield line-clear controller and its helpers.
package grid_pkg;

  localparam int GRID_ROWS = 20;
  localparam int GRID_COLS = 10;
  localparam int CELL_W    = 4;

  typedef logic [CELL_W-1:0]                         cell_t;
  typedef cell_t [GRID_COLS-1:0]                     row_t;
  typedef cell_t [GRID_ROWS-1:0][GRID_COLS-1:0]      grid_t;

  localparam cell_t CELL_EMPTY = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } lc_state_t;

endpackage

// File: rtl/grid_line_clear_ctrl_row_full_detect.sv
// row_full_detect: flags a playfield row whose cells are all non-empty.
//   row_i  : one row of GRID_COLS cells
//   full_o : 1 when no cell in the row is CELL_EMPTY
module row_full_detect
  import grid_pkg::*;
(
  input  row_t row_i,
  output logic full_o
);

  always_comb begin
    full_o = 1'b1;
    for (int c = 0; c < GRID_COLS; c++) begin
      if (row_i[c] == CELL_EMPTY) full_o = 1'b0;
    end
  end

endmodule

// File: rtl/grid_line_clear_ctrl.sv
// grid_line_clear_ctrl: owns the playfield cell storage, accepts single-cell
// lock writes, and on request removes full rows bottom-to-top, collapsing the
// rows above and reporting the count.
//   clk, rst_n          : clock, async active-low reset
//   grid_clear          : synchronous wipe, overrides everything
//   lock_valid/row/col/color, lock_ready : cell write port (IDLE only)
//   scan_start, busy, done               : scan handshake
//   lines_cleared, total_lines           : last-scan count, saturating total
//   game_grid_array                      : registered grid for the renderer
//
// state | meaning
// IDLE  | accept lock writes and scan_start
// CHECK | test row row_ptr for fullness, walk upward
// SHIFT | drop rows 0..row_ptr-1 down by one, inject empty row 0
// DONE  | publish clr_cnt, pulse done
module grid_line_clear_ctrl
  import grid_pkg::*;
(
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          grid_clear,
  input  logic                                          lock_valid,
  input  logic [4:0]                                    lock_row,
  input  logic [3:0]                                    lock_col,
  input  logic [CELL_W-1:0]                             lock_color,
  output logic                                          lock_ready,
  input  logic                                          scan_start,
  output logic                                          busy,
  output logic                                          done,
  output logic [4:0]                                    lines_cleared,
  output logic [15:0]                                   total_lines,
  output logic [GRID_ROWS-1:0][GRID_COLS-1:0][CELL_W-1:0] game_grid_array
);

  localparam logic [4:0] ROW_LIMIT = 5'(GRID_ROWS);
  localparam logic [3:0] COL_LIMIT = 4'(GRID_COLS);

  lc_state_t   state_q, state_d;
  logic [4:0]  row_ptr_q, row_ptr_d;
  logic [4:0]  clr_cnt_q, clr_cnt_d;
  grid_t       grid_q, grid_d;
  logic [4:0]  lines_q, lines_d;
  logic [15:0] total_q, total_d;
  logic [16:0] total_sum;
  logic        row_full;

  // row_ptr never exceeds GRID_ROWS-1, so the select stays in range.
  row_full_detect u_row_full (
    .row_i  (grid_q[row_ptr_q]),
    .full_o (row_full)
  );

  assign total_sum = {1'b0, total_q} + {12'd0, clr_cnt_q};

  always_comb begin
    state_d   = state_q;
    row_ptr_d = row_ptr_q;
    clr_cnt_d = clr_cnt_q;
    grid_d    = grid_q;
    lines_d   = lines_q;
    total_d   = total_q;

    if (grid_clear) begin
      state_d   = IDLE;
      row_ptr_d = '0;
      clr_cnt_d = '0;
      grid_d    = '0;
      lines_d   = '0;
      total_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (lock_valid && (lock_row < ROW_LIMIT) && (lock_col < COL_LIMIT))
            grid_d[lock_row][lock_col] = lock_color;
          if (scan_start) begin
            row_ptr_d = ROW_LIMIT - 5'd1;
            clr_cnt_d = '0;
            state_d   = CHECK;
          end
        end
        CHECK: begin
          if (row_full) begin
            clr_cnt_d = clr_cnt_q + 5'd1;
            state_d   = SHIFT;
          end else if (row_ptr_q == 5'd0) begin
            state_d = DONE;
          end else begin
            row_ptr_d = row_ptr_q - 5'd1;
          end
        end
        SHIFT: begin
          // row_ptr is held so the row that just moved in gets rechecked.
          for (int r = 1; r < GRID_ROWS; r++) begin
            if (5'(r) <= row_ptr_q) grid_d[r] = grid_q[r-1];
          end
          grid_d[0] = '0;
          state_d   = CHECK;
        end
        DONE: begin
          lines_d = clr_cnt_q;
          total_d = total_sum[16] ? 16'hFFFF : total_sum[15:0];
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_ptr_q <= '0;
      clr_cnt_q <= '0;
      grid_q    <= '0;
      lines_q   <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_ptr_q <= row_ptr_d;
      clr_cnt_q <= clr_cnt_d;
      grid_q    <= grid_d;
      lines_q   <= lines_d;
      total_q   <= total_d;
    end
  end

  assign lock_ready      = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign done            = (state_q == DONE);
  assign lines_cleared   = lines_q;
  assign total_lines     = total_q;
  assign game_grid_array = grid_q;

endmodule

// File: tb/tb_grid_line_clear_ctrl.sv
module tb_grid_line_clear_ctrl;
  import grid_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        grid_clear;
  logic        lock_valid;
  logic [4:0]  lock_row;
  logic [3:0]  lock_col;
  logic [3:0]  lock_color;
  logic        lock_ready;
  logic        scan_start;
  logic        busy;
  logic        done;
  logic [4:0]  lines_cleared;
  logic [15:0] total_lines;
  logic [GRID_ROWS-1:0][GRID_COLS-1:0][CELL_W-1:0] game_grid_array;

  int tests_run = 0;
  int tests_failed = 0;
  logic [3:0] exp_g [GRID_ROWS][GRID_COLS];

  typedef struct {
    logic       valid;
    logic [4:0] row;
    logic [3:0] col;
    logic [3:0] color;
    int         prow;
    int         pcol;
    logic [3:0] pexp;
  } wr_vec_t;

  wr_vec_t vecs [7];

  always #5 clk = ~clk;

  grid_line_clear_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .grid_clear      (grid_clear),
    .lock_valid      (lock_valid),
    .lock_row        (lock_row),
    .lock_col        (lock_col),
    .lock_color      (lock_color),
    .lock_ready      (lock_ready),
    .scan_start      (scan_start),
    .busy            (busy),
    .done            (done),
    .lines_cleared   (lines_cleared),
    .total_lines     (total_lines),
    .game_grid_array (game_grid_array)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_exp();
    for (int r = 0; r < GRID_ROWS; r++)
      for (int c = 0; c < GRID_COLS; c++) exp_g[r][c] = 4'd0;
  endtask

  task automatic check_grid(input string name);
    int mism = 0;
    for (int r = 0; r < GRID_ROWS; r++)
      for (int c = 0; c < GRID_COLS; c++)
        if (game_grid_array[r][c] !== exp_g[r][c]) mism++;
    check(name, 32'(mism), 32'd0);
  endtask

  // All drive tasks start and end at a negedge.
  task automatic write_cell(input int r, input int c, input logic [3:0] col);
    lock_valid = 1'b1; lock_row = 5'(r); lock_col = 4'(c); lock_color = col;
    @(negedge clk);
    lock_valid = 1'b0;
  endtask

  task automatic fill_row(input int r, input logic [3:0] col);
    for (int c = 0; c < GRID_COLS; c++) write_cell(r, c, col);
  endtask

  task automatic pulse_clear();
    grid_clear = 1'b1;
    @(negedge clk);
    grid_clear = 1'b0;
  endtask

  task automatic run_scan(input string name, input int exp_cycle, input logic [4:0] exp_lines,
                          input logic [15:0] exp_total, input bit hammer);
    int at = 0;
    int extra = 0;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    check({name, "_busy"}, 32'(busy), 32'd1);
    for (int n = 1; n <= 80 && at == 0; n++) begin
      if (done) at = n;
      else begin
        if (hammer && n == 5) check({name, "_lock_ready_busy"}, 32'(lock_ready), 32'd0);
        if (hammer && n >= 2 && n <= 10) begin
          lock_valid = 1'b1; lock_row = 5'd0; lock_col = 4'd0; lock_color = 4'd9;
          scan_start = 1'b1;
        end else begin
          lock_valid = 1'b0; scan_start = 1'b0;
        end
        @(negedge clk);
      end
    end
    lock_valid = 1'b0; scan_start = 1'b0;
    check({name, "_done_cycle"}, 32'(at), 32'(exp_cycle));
    @(negedge clk);
    check({name, "_done_single"}, 32'(done), 32'd0);
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_lines"}, 32'(lines_cleared), 32'(exp_lines));
    check({name, "_total"}, 32'(total_lines), 32'(exp_total));
    for (int n = 0; n < 30; n++) begin
      if (done) extra++;
      @(negedge clk);
    end
    check({name, "_no_extra_done"}, 32'(extra), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd0,  4'd0,  4'd3,  0,  0, 4'd3};
    vecs[1] = '{1'b1, 5'd19, 4'd9,  4'd15, 19, 9, 4'd15};
    vecs[2] = '{1'b1, 5'd20, 4'd0,  4'd4,  19, 0, 4'd0};
    vecs[3] = '{1'b1, 5'd5,  4'd10, 4'd6,  5,  9, 4'd0};
    vecs[4] = '{1'b0, 5'd7,  4'd7,  4'd9,  7,  7, 4'd0};
    vecs[5] = '{1'b1, 5'd0,  4'd0,  4'd0,  0,  0, 4'd0};
    vecs[6] = '{1'b1, 5'd19, 4'd9,  4'd0,  19, 9, 4'd0};

    rst_n = 1'b0; grid_clear = 1'b0; lock_valid = 1'b0; lock_row = '0;
    lock_col = '0; lock_color = '0; scan_start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    clear_exp();
    check("rst_lock_ready", 32'(lock_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_total", 32'(total_lines), 32'd0);
    check_grid("rst_grid");

    for (int i = 0; i < 7; i++) begin
      lock_valid = vecs[i].valid; lock_row = vecs[i].row;
      lock_col = vecs[i].col; lock_color = vecs[i].color;
      @(negedge clk);
      lock_valid = 1'b0;
      check($sformatf("wr_vec%0d", i), 32'(game_grid_array[vecs[i].prow][vecs[i].pcol]),
            32'(vecs[i].pexp));
    end
    check_grid("wr_table_grid");

    run_scan("empty", 21, 5'd0, 16'd0, 1'b0);
    check_grid("empty_grid");

    fill_row(19, 4'd1);
    write_cell(18, 3, 4'd2);
    run_scan("one", 23, 5'd1, 16'd1, 1'b0);
    clear_exp(); exp_g[19][3] = 4'd2;
    check_grid("one_grid");

    pulse_clear();
    check("clr_total", 32'(total_lines), 32'd0);
    for (int r = 16; r < 20; r++) fill_row(r, 4'(r - 13));
    write_cell(15, 0, 4'd5);
    run_scan("four", 29, 5'd4, 16'd4, 1'b0);
    clear_exp(); exp_g[19][0] = 4'd5;
    check_grid("four_grid");

    pulse_clear();
    fill_row(19, 4'd3);
    fill_row(17, 4'd3);
    for (int c = 0; c < 5; c++) write_cell(18, c, 4'd4);
    run_scan("gap", 25, 5'd2, 16'd2, 1'b0);
    clear_exp();
    for (int c = 0; c < 5; c++) exp_g[19][c] = 4'd4;
    check_grid("gap_grid");

    write_cell(20, 0, 4'd6);
    check_grid("oob_row_grid");
    run_scan("hammer", 21, 5'd0, 16'd2, 1'b1);
    check_grid("hammer_grid");

    // Row 19 full: cycle 1 CHECK, cycle 2 SHIFT; wipe during SHIFT.
    fill_row(19, 4'd2);
    begin
      int extra = 0;
      scan_start = 1'b1;
      @(negedge clk);
      scan_start = 1'b0;
      @(negedge clk);
      check("midclr_busy_before", 32'(busy), 32'd1);
      grid_clear = 1'b1;
      @(negedge clk);
      grid_clear = 1'b0;
      check("midclr_busy", 32'(busy), 32'd0);
      check("midclr_total", 32'(total_lines), 32'd0);
      check("midclr_lines", 32'(lines_cleared), 32'd0);
      clear_exp();
      check_grid("midclr_grid");
      for (int n = 0; n < 30; n++) begin
        if (done) extra++;
        @(negedge clk);
      end
      check("midclr_no_done", 32'(extra), 32'd0);
    end

    force dut.total_q = 16'hFFFE;
    @(posedge clk);
    #1 release dut.total_q;
    @(negedge clk);
    check("preset_total", 32'(total_lines), 32'hFFFE);
    for (int r = 17; r < 20; r++) fill_row(r, 4'd7);
    run_scan("sat", 27, 5'd3, 16'hFFFF, 1'b0);
    check_grid("sat_grid");

    fill_row(0, 4'd8);
    run_scan("row0", 23, 5'd1, 16'hFFFF, 1'b0);
    check_grid("row0_grid");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/grid_line_clear_ctrl.md
Name: grid_line_clear_ctrl

Overview:
- Owns the playfield cell storage and drives the grid array consumed by the block renderer.
- Accepts single-cell lock writes from the piece logic.
- On request, scans the grid bottom-to-top, removes every full row, collapses the rows above it, and reports the number of lines cleared.
- Sits between the game-logic FSM (writer/requester) and the renderer (read-only consumer).

Parameters:
- GRID_ROWS, 20, number of playfield rows; row 0 is the top.
- GRID_COLS, 10, number of playfield columns.
- CELL_W, 4, bits per cell colour code; 0 means empty.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- grid_clear  in  1  synchronous wipe for a new game; highest priority.
- lock_valid  in  1  write one cell this cycle.
- lock_row  in  5  row index of the write.
- lock_col  in  4  column index of the write.
- lock_color  in  CELL_W  colour code to store.
- lock_ready  out  1  high when lock writes are accepted (state IDLE).
- scan_start  in  1  request a line-clear scan.
- busy  out  1  high in CHECK, SHIFT and DONE.
- done  out  1  single-cycle pulse when a scan completes.
- lines_cleared  out  5  rows removed by the last completed scan.
- total_lines  out  16  running total of cleared lines, saturating.
- game_grid_array  out  [GRID_ROWS-1:0][GRID_COLS-1:0][CELL_W-1:0]  registered grid contents.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all cells 0, state IDLE, lock_ready=1, busy=0, done=0, lines_cleared=0, total_lines=0.
- Combinational outputs: lock_ready = (state==IDLE). busy = (state!=IDLE).
- Registered outputs: game_grid_array, lines_cleared and total_lines are registered. Updates are visible the cycle after the causing edge.
- grid_clear, in any state:
  - All cells go to 0 and the state goes to IDLE.
  - lines_cleared and total_lines go to 0. No done pulse.
  - Any lock write or scan_start in the same cycle is ignored.
- Lock write: accepted only in IDLE with lock_valid=1.
  - Sets cell[lock_row][lock_col] to lock_color.
  - Ignored if lock_row>=GRID_ROWS or lock_col>=GRID_COLS.
  - Writing colour 0 is legal and empties the cell.
  - lock_valid outside IDLE is ignored. No queuing.
- Scan acceptance: scan_start in IDLE is accepted.
  - Sets row_ptr=GRID_ROWS-1 and clr_cnt=0, then goes to CHECK.
  - scan_start outside IDLE is ignored.
  - scan_start together with a lock write: the write is applied and the scan starts. The first CHECK sees the written cell.
- FSM:
  - IDLE: handles lock writes and scan_start as above.
  - CHECK: a row is full when all GRID_COLS cells are nonzero.
    - Row row_ptr full: clr_cnt+=1, go to SHIFT.
    - Else if row_ptr==0: go to DONE.
    - Else: row_ptr-=1 and stay in CHECK.
  - SHIFT (one cycle): every row r with 1<=r<=row_ptr takes the contents of row r-1, and row 0 becomes all zero. Rows below row_ptr are unchanged. row_ptr is not decremented, so the row that moved in is rechecked. Go to CHECK.
  - DONE (one cycle): done=1 and lines_cleared<=clr_cnt. total_lines<=min(total_lines+clr_cnt, 16'hFFFF). Go to IDLE.
- Latency: with k full rows removed, done is high in cycle GRID_ROWS+2k+1 after the accepting edge. With k=0 that is cycle 21.
- Termination: each SHIFT injects an empty row 0, so the scan always ends. clr_cnt is at most GRID_ROWS and fits in 5 bits.
- Row 0 full: SHIFT zeroes it, the recheck finds it empty, and the FSM goes to DONE.
- Reset mid-scan: the asynchronous return to reset values; partial shifts are discarded together with the grid.

Decomposition:
- Package grid_pkg holds:
  - GRID_ROWS, GRID_COLS, CELL_W.
  - typedef cell_t (logic [CELL_W-1:0]).
  - typedef grid_t (cell_t [GRID_ROWS-1:0][GRID_COLS-1:0]).
  - CELL_EMPTY = 0.
  - Enum lc_state_t {IDLE, CHECK, SHIFT, DONE}.
- Sub-module row_full_detect: combinational; one row of cells in, a single full flag out. It is instantiated once on the row_ptr-selected row.

Test Plan:
- Reset, then scan_start on an empty grid -> done in cycle 21, lines_cleared=0, total_lines=0, grid all 0.
- Fill row 19 with colour 1 and place colour 2 at (18,3); scan -> done in cycle 23, lines_cleared=1, (19,3)=2, all other cells 0, total_lines=1.
- Fill rows 16-19 and place colour 5 at (15,0); scan -> lines_cleared=4, done in cycle 29, (19,0)=5, total_lines=4.
- Fill rows 19 and 17 with row 18 half-filled; scan -> lines_cleared=2, the old row 18 ends up at row 19.
- Lock write at (20,0) and lock_valid during busy -> grid unchanged. scan_start while busy -> exactly one done pulse.
- grid_clear mid-scan (SHIFT state) -> next cycle busy=0, grid all 0, total_lines=0, no done. Preset total_lines=16'hFFFE and clear 3 lines -> total_lines=16'hFFFF.
